// File: rtl/instr_trace_sched_pkg.sv
// Shared types and constants for the instruction trace scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instr_trace_sched_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_DECODE = 1'b1
  } state_t;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int          TRACE_STR_W = 256;
  localparam int          SEQ_W       = 16;

  // Saturating 16-bit increment, used by the drop counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/instr_trace_sched_trace_fifo.sv
// Generic DEPTH-entry synchronous FIFO with count/full/empty flags.
// Latency: a pushed entry is visible at dout_o the cycle after the push.
// Backpressure: push when full and pop when empty are ignored; head reads as zero when empty.
module trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Storage array: written on accepted push, no reset needed since the head is gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/instr_trace_sched.sv
// Round-robin scheduler sharing one disassembly decoder; decoded strings buffered for a trace port.
// Latency: grant in cycle N, dec_instr valid N+1, trace entry visible N+2 from an empty FIFO.
// Backpressure: full FIFO withholds req_ready; with TRACE_DROP_EN full-FIFO requests are granted and dropped.
module instr_trace_sched
  import instr_trace_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int SRCW  = 2,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [32*NREQ-1:0]      req_instr,
  output logic [NREQ-1:0]         req_ready,
  output logic [31:0]             dec_instr,
  input  logic [TRACE_STR_W-1:0]  dec_str,
  output logic                    trace_valid,
  input  logic                    trace_ready,
  output logic [TRACE_STR_W-1:0]  trace_str,
  output logic [SRCW-1:0]         trace_src,
  output logic [SEQ_W-1:0]        trace_seq,
  output logic [15:0]             drop_cnt
);

  localparam int ENTRY_W = TRACE_STR_W + SRCW + SEQ_W;
  localparam int CNTW    = $clog2(DEPTH) + 1;
`ifdef TRACE_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  state_t            state_q, state_d;
  logic [SRCW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [SRCW-1:0]   src_q, src_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [31:0]       dec_instr_q, dec_instr_d;

  logic [31:0]       instr_arr [NREQ];
  logic              gnt_found;
  logic [SRCW-1:0]   gnt_idx, cand_idx, rr_next;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNTW-1:0]   fifo_count;
  logic [ENTRY_W-1:0] fifo_dout;

  for (genvar i = 0; i < NREQ; i++) begin : g_instr
    assign instr_arr[i] = req_instr[32*i +: 32];
  end

  // Pick the first valid requester at or after rr_ptr, wrapping NREQ-1 to 0.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_idx = SRCW'((int'(rr_ptr_q) + k) % NREQ);
      if (!gnt_found && req_valid[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  assign rr_next = (gnt_idx == SRCW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;

  // FSM next state, grant pulse and datapath next values; the full check happens only in IDLE.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    src_d       = src_q;
    seq_d       = seq_q;
    dec_instr_d = dec_instr_q;
    req_ready   = '0;
    fifo_push   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_found && (!fifo_full || DROP_EN)) begin
          req_ready[gnt_idx] = 1'b1;
          rr_ptr_d           = rr_next;
          if (fifo_full) begin
            // Dropped request still consumes a sequence number so the gap shows downstream.
            seq_d = seq_q + 16'd1;
          end else begin
            state_d     = ST_DECODE;
            dec_instr_d = instr_arr[gnt_idx];
            src_d       = gnt_idx;
          end
        end
      end
      ST_DECODE: begin
        fifo_push = 1'b1;
        seq_d     = seq_q + 16'd1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      src_q       <= '0;
      seq_q       <= '0;
      dec_instr_q <= NOP_INSTR;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      src_q       <= src_d;
      seq_q       <= seq_d;
      dec_instr_q <= dec_instr_d;
    end
  end

  assign dec_instr = dec_instr_q;

`ifdef TRACE_DROP_EN
  logic [15:0] drop_cnt_q;

  // Count requests granted while the FIFO was full, saturating at 0xFFFF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (state_q == ST_IDLE && gnt_found && fifo_full) begin
      drop_cnt_q <= sat_inc16(drop_cnt_q);
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

  assign fifo_pop    = trace_ready && !fifo_empty;
  assign trace_valid = (fifo_count != '0);

  trace_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .din_i   ({dec_str, src_q, seq_q}),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign {trace_str, trace_src, trace_seq} = fifo_dout;

endmodule

// File: tb/tb_instr_trace_sched.sv
// Self-checking bench for instr_trace_sched with a scoreboard on the trace port.
// Latency: checks grant at N, dec_instr at N+1, trace entry at N+2.
// Backpressure: exercises full-FIFO stall (or drops when TRACE_DROP_EN is defined).
`timescale 1ns/1ps
module tb_instr_trace_sched;
  localparam int NREQ  = 4;
  localparam int SRCW  = 2;
  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [32*NREQ-1:0] req_instr;
  logic [NREQ-1:0]    req_ready;
  logic [31:0]        dec_instr;
  logic [255:0]       dec_str;
  logic               trace_valid;
  logic               trace_ready;
  logic [255:0]       trace_str;
  logic [SRCW-1:0]    trace_src;
  logic [15:0]        trace_seq;
  logic [15:0]        drop_cnt;

  typedef struct {
    logic [SRCW-1:0] src;
    logic [15:0]     seq;
    logic [255:0]    str;
  } exp_t;

  typedef struct {
    logic [NREQ-1:0] valid;
    logic [NREQ-1:0] gnt;
  } vec_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] seq_m  = 16'd0;
  int          vec_n  = 0;

  instr_trace_sched #(.NREQ(NREQ), .SRCW(SRCW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_instr   (req_instr),
    .req_ready   (req_ready),
    .dec_instr   (dec_instr),
    .dec_str     (dec_str),
    .trace_valid (trace_valid),
    .trace_ready (trace_ready),
    .trace_str   (trace_str),
    .trace_src   (trace_src),
    .trace_seq   (trace_seq),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  // Stand-in for the external decoder: any fixed, instruction-dependent pattern.
  function automatic logic [255:0] fake_dec(input logic [31:0] x);
    return {x, ~x, x ^ 32'hA5A5_5A5A, {x[15:0], x[31:16]},
            x + 32'd1, x - 32'd7, {x[7:0], x[31:8]}, x ^ 32'h2020_2020};
  endfunction

  assign dec_str = fake_dec(dec_instr);

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [SRCW-1:0] onehot_idx(input logic [NREQ-1:0] oh);
    logic [SRCW-1:0] r = '0;
    for (int i = 0; i < NREQ; i++) if (oh[i]) r = SRCW'(i);
    return r;
  endfunction

  task automatic sb_push(input logic [NREQ-1:0] gnt);
    exp_t e;
    e.src = onehot_idx(gnt);
    e.seq = seq_m;
    e.str = fake_dec(req_instr[32*int'(e.src) +: 32]);
    sb_q.push_back(e);
    seq_m++;
  endtask

  task automatic set_instr();
    for (int i = 0; i < NREQ; i++)
      req_instr[32*i +: 32] = 32'h0010_0093 + (i << 20) + (vec_n << 7);
    vec_n++;
  endtask

  // One request in an IDLE cycle; entered and left at posedge+1 with the FSM in IDLE.
  task automatic do_req(input logic [NREQ-1:0] valid, input logic [NREQ-1:0] gnt, input string name);
    set_instr();
    req_valid = valid;
    @(negedge clk);
    check(name, req_ready, gnt);
    if (gnt != '0) sb_push(gnt);
    @(posedge clk); #1;
    req_valid = '0;
    if (gnt != '0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input string name);
    bit done = 0;
    trace_ready = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (!trace_valid) done = 1;
    end
    #1;
    check({name, "_empty"}, trace_valid, 1'b0);
    check({name, "_sb_left"}, sb_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Scoreboard consumer: every accepted trace entry must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && trace_valid && trace_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL trace_unexpected: got seq %0h src %0d expected no entry", trace_seq, trace_src);
      end else begin
        mon_e = sb_q.pop_front();
        check("trace_src", trace_src, mon_e.src);
        check("trace_seq", trace_seq, mon_e.seq);
        check("trace_str", trace_str, mon_e.str);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[10];
    int   pulses;
    tbl[0] = '{4'b1111, 4'b0010};
    tbl[1] = '{4'b1111, 4'b0100};
    tbl[2] = '{4'b1111, 4'b1000};
    tbl[3] = '{4'b1111, 4'b0001};
    tbl[4] = '{4'b0001, 4'b0001};
    tbl[5] = '{4'b1001, 4'b1000};
    tbl[6] = '{4'b0110, 4'b0010};
    tbl[7] = '{4'b0000, 4'b0000};
    tbl[8] = '{4'b0011, 4'b0001};
    tbl[9] = '{4'b1100, 4'b0100};

    rst_n       = 1'b0;
    req_valid   = '0;
    req_instr   = '0;
    trace_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 4'b0000);
    check("rst_trace_valid", trace_valid, 1'b0);
    check("rst_dec_instr", dec_instr, 32'h0000_0013);
    check("rst_trace_str", trace_str, 256'h0);
    check("rst_trace_src", trace_src, 2'd0);
    check("rst_trace_seq", trace_seq, 16'h0);
    check("rst_drop_cnt", drop_cnt, 16'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single request, cycle by cycle.
    req_valid = 4'b0001;
    req_instr[31:0] = 32'h0050_0093;
    @(negedge clk);
    check("first_grant_N", req_ready, 4'b0001);
    sb_push(4'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("first_dec_instr_N1", dec_instr, 32'h0050_0093);
    check("first_no_grant_decode", req_ready, 4'b0000);
    check("first_trace_valid_N1", trace_valid, 1'b0);
    @(negedge clk);
    check("first_trace_valid_N2", trace_valid, 1'b1);
    check("first_trace_src_N2", trace_src, 2'd0);
    check("first_trace_seq_N2", trace_seq, 16'd0);
    @(posedge clk); #1;

    // Round-robin vectors.
    for (int v = 0; v < 10; v++) do_req(tbl[v].valid, tbl[v].gnt, "rr_table");

    // All four valid continuously: a grant every other cycle, rotating from 3.
    set_instr();
    req_valid = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      logic [NREQ-1:0] exp_g;
      exp_g = (k % 2 == 0) ? NREQ'(1 << ((3 + k / 2) % NREQ)) : '0;
      @(negedge clk);
      check("continuous_grant", req_ready, exp_g);
      if (exp_g != '0) sb_push(exp_g);
      @(posedge clk); #1;
    end
    req_valid = '0;
    drain("continuous");

`ifndef TRACE_DROP_EN
    // Backpressure: FIFO fills to DEPTH, grants stop, one pop lets exactly one more in.
    trace_ready = 1'b0;
    set_instr();
    req_valid = 4'b0001;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        pulses++;
        check("bp_grant", req_ready, 4'b0001);
        sb_push(req_ready);
      end
      @(posedge clk); #1;
    end
    check("bp_grants_until_full", pulses, DEPTH);
    trace_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_while_full", req_ready, 4'b0000);
    @(posedge clk); #1;
    trace_ready = 1'b0;
    @(negedge clk);
    check("bp_resume_after_pop", req_ready, 4'b0001);
    sb_push(4'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    drain("bp");
    check("no_drop_cnt", drop_cnt, 16'h0);
`else
    // Drop mode: 4 accepted entries fill the FIFO, then 3 granted-and-dropped requests.
    trace_ready = 1'b0;
    set_instr();
    req_valid = 4'b0001;
    pulses = 0;
    for (int c = 0; c < 30 && pulses < 7; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        pulses++;
        check("drop_grant", req_ready, 4'b0001);
        if (pulses <= DEPTH) sb_push(req_ready);
        else seq_m++;
        if (pulses == 7) req_valid = '0;
      end
      @(posedge clk); #1;
    end
    check("drop_pulses", pulses, 7);
    check("drop_cnt_3", drop_cnt, 16'd3);
    drain("drop");
    do_req(4'b0001, 4'b0001, "drop_after_gap");
    drain("drop_gap");
`endif

    // Sequence wrap 0xFFFF -> 0x0000.
    force dut.seq_q = 16'hFFFE;
    #1;
    release dut.seq_q;
    seq_m = 16'hFFFE;
    do_req(4'b0001, 4'b0001, "wrap_req0");
    do_req(4'b0001, 4'b0001, "wrap_req1");
    do_req(4'b0001, 4'b0001, "wrap_req2");
    drain("wrap");

    // Reset during DECODE discards the in-flight entry and the buffered one.
    trace_ready = 1'b0;
    do_req(4'b0001, 4'b0001, "rstmid_fill");
    set_instr();
    req_valid = 4'b0010;
    @(negedge clk);
    check("rstmid_grant", req_ready, 4'b0010);
    @(posedge clk); #2;
    req_valid = '0;
    rst_n = 1'b0;
    sb_q.delete();
    seq_m = 16'd0;
    #1;
    check("rstmid_trace_valid", trace_valid, 1'b0);
    check("rstmid_dec_instr", dec_instr, 32'h0000_0013);
    check("rstmid_trace_seq", trace_seq, 16'h0);
    check("rstmid_req_ready", req_ready, 4'b0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    trace_ready = 1'b1;
    @(posedge clk); #1;
    do_req(4'b1111, 4'b0001, "rstmid_rr_restart");
    drain("rstmid");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
